// File: rtl/frame_mem_arbiter.sv
// Frame memory arbiter: VGA fetch (fixed high priority) vs. processor command port.
// Optional stall statistics counter built only when FRAME_ARB_STATS_EN is defined.
module frame_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cmd_valid,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              cmd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic [15:0]       stall_count
);

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_CMD} tag_t;

    state_t            state_q, state_d;
    tag_t              tag_q [MEM_LAT];
    tag_t              tag_in;
    tag_t              tag_out;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic [DATA_W-1:0] vga_data_q, rd_data_q;
    logic              vga_valid_q, rd_valid_q;
    logic              ready;

    assign ready   = rst_n & (state_q == IDLE) & ~vga_req;
    assign tag_out = tag_q[MEM_LAT-1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wren_d  = 1'b0;
        tag_in  = TAG_NONE;
        if (vga_req) begin
            addr_d = vga_addr;
            tag_in = TAG_VGA;
        end else if (cmd_valid && ready) begin
            addr_d = cmd_addr;
            if (cmd_we) begin
                wren_d  = 1'b1;
                wdata_d = cmd_wdata;
            end else begin
                tag_in  = TAG_CMD;
                state_d = RD_WAIT;
            end
        end
        // Release the command port only once the read data has been presented.
        if (state_q == RD_WAIT && rd_valid_q)
            state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wren_q      <= 1'b0;
            vga_data_q  <= '0;
            rd_data_q   <= '0;
            vga_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            for (int i = 0; i < MEM_LAT; i++)
                tag_q[i] <= TAG_NONE;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wren_q      <= wren_d;
            tag_q[0]    <= tag_in;
            for (int i = 1; i < MEM_LAT; i++)
                tag_q[i] <= tag_q[i-1];
            vga_valid_q <= (tag_out == TAG_VGA);
            rd_valid_q  <= (tag_out == TAG_CMD);
            if (tag_out == TAG_VGA)
                vga_data_q <= mem_q;
            if (tag_out == TAG_CMD)
                rd_data_q <= mem_q;
        end
    end

`ifdef FRAME_ARB_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cmd_valid && !ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

    assign cmd_ready = ready;
    assign mem_addr  = addr_q;
    assign mem_data  = wdata_q;
    assign mem_wren  = wren_q;
    assign vga_data  = vga_data_q;
    assign vga_valid = vga_valid_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter with a MEM_LAT=2 behavioural memory.
module tb_frame_mem_arbiter;
    localparam int LAT = 2;
`ifdef FRAME_ARB_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd10;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vga_req;
    logic [15:0] vga_addr;
    logic [7:0]  vga_data;
    logic        vga_valid;
    logic        cmd_valid, cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        cmd_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [7:0]  mem_q;
    logic [15:0] stall_count;

    frame_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
        .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Memory: registered mem_addr plus one output register, write-first.
    logic [7:0] mem [65536];
    logic [7:0] ref_mem [65536];
    logic [7:0] q_r;
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr] = mem_data;
        q_r <= mem[mem_addr];
    end
    assign mem_q = q_r;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    typedef struct {logic [7:0] d; int due;} exp_t;
    exp_t vq[$];
    exp_t rq[$];
    exp_t e;

    always @(negedge clk) if (cyc > 0) begin
        while (vq.size() > 0 && vq[0].due < cyc) begin
            chk("vga_late", cyc, vq[0].due);
            void'(vq.pop_front());
        end
        while (rq.size() > 0 && rq[0].due < cyc) begin
            chk("rd_late", cyc, rq[0].due);
            void'(rq.pop_front());
        end
        if (vga_valid === 1'b1) begin
            if (vq.size() == 0) chk("vga_extra", 1, 0);
            else begin
                e = vq.pop_front();
                chk("vga_time", cyc, e.due);
                chk("vga_data", vga_data, e.d);
            end
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) chk("rd_extra", 1, 0);
            else begin
                e = rq.pop_front();
                chk("rd_time", cyc, e.due);
                chk("rd_data", rd_data, e.d);
            end
        end
        if (!rst_n) begin
            vq.delete();
            rq.delete();
        end else begin
            if (vga_req) vq.push_back('{ref_mem[vga_addr], cyc + LAT + 1});
            if (cmd_valid && cmd_ready) begin
                if (cmd_we) ref_mem[cmd_addr] = cmd_wdata;
                else rq.push_back('{ref_mem[cmd_addr], cyc + LAT + 1});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_vga_data", vga_data, 0);
        chk("rst_vga_valid", vga_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_stall", stall_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    logic acc;

    initial begin
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = a[7:0];
            ref_mem[a] = a[7:0];
        end
        rst_n = 1'b0; vga_req = 1'b1; vga_addr = 16'h0055;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0066; cmd_wdata = 8'h00;

        // Reset with both requesters active
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset_outputs();
        end
        rst_n = 1'b1; cmd_valid = 1'b0;
        tick();
        vga_req = 1'b0;
        tick(5);

        // VGA stream 0x0100..0x0107
        for (int i = 0; i < 8; i++) begin
            vga_req = 1'b1; vga_addr = 16'h0100 + 16'(i);
            tick();
        end
        vga_req = 1'b0;
        tick(5);

        // Address wrap: last and first address back to back
        vga_req = 1'b1; vga_addr = 16'hFFFF; tick();
        vga_addr = 16'h0000; tick();
        vga_req = 1'b0; tick(5);

        // Write blocked by an active line, issued on the first blanking cycle
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h1234; cmd_wdata = 8'hA5;
        vga_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            vga_addr = 16'h0200 + 16'(i);
            #1;
            chk("cf_ready_lo", cmd_ready, 0);
            if (i > 0) chk("cf_no_wren", mem_wren, 0);
            tick();
        end
        vga_req = 1'b0;
        #1;
        chk("cf_ready_hi", cmd_ready, 1);
        chk("stall_count", stall_count, EXP_STALL);
        tick();
        cmd_valid = 1'b0;
        chk("cf_wren", mem_wren, 1);
        chk("cf_addr", mem_addr, 16'h1234);
        chk("cf_wdata", mem_data, 8'hA5);
        tick();
        chk("cf_wren_pulse", mem_wren, 0);
        chk("cf_addr_hold", mem_addr, 16'h1234);
        chk("stall_hold", stall_count, EXP_STALL);
        tick(3);

        // Write then immediate read of the same address
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 16'h0010; cmd_wdata = 8'h3C;
        #1; chk("raw_wr_ready", cmd_ready, 1);
        tick();
        cmd_we = 1'b0;
        #1; chk("raw_rd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; chk("raw_wait_ready", cmd_ready, 0);
            tick();
        end
        chk("raw_ready_back", cmd_ready, 1);
        chk("raw_rd_hold", rd_data, 8'h3C);
        tick(3);

        // Reset while a read is outstanding
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 16'h0020;
        tick();
        cmd_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1; chk("rr_idle_ready", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            chk("rr_no_rd_valid", rd_valid, 0);
            tick();
        end
        cmd_valid = 1'b1; cmd_addr = 16'h0030;
        tick();
        cmd_valid = 1'b0;
        tick(6);

        // Mixed random traffic on a small address window
        for (int n = 0; n < 400; n++) begin
            vga_req  = ($urandom_range(0, 3) == 0);
            vga_addr = 16'($urandom_range(0, 31));
            if (!cmd_valid && $urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'($urandom_range(0, 1));
                cmd_addr  = 16'($urandom_range(0, 15));
                cmd_wdata = 8'($urandom);
            end
            #1;
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        vga_req = 1'b0; cmd_valid = 1'b0;
        tick(10);
        chk("vga_q_drained", vq.size(), 0);
        chk("rd_q_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_mem_arbiter.md
Name: frame_mem_arbiter

Overview:
- Sequences and shares the single-port frame memory (8-bit pixels, 16-bit address) between two requesters:
  - the VGA pixel fetch path, which has fixed highest priority and no backpressure;
  - a processor/loader command port (valid/ready), which has lowest priority.
- Sits between the memory instance and the image drawing/processing logic.
- Issues at most one memory access per clock and routes returned read data back to the requester that issued it.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, pixel width.
- MEM_LAT, 2, read latency in cycles from mem_addr valid to mem_q valid (legal range 1..4).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- vga_req  in  1  VGA fetch strobe; may be high every cycle.
- vga_addr  in  ADDR_W  VGA fetch address.
- vga_data  out  DATA_W  returned VGA pixel.
- vga_valid  out  1  one-cycle pulse; vga_data is valid.
- cmd_valid  in  1  processor command valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  command address.
- cmd_wdata  in  DATA_W  write data.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- rd_data  out  DATA_W  processor read data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- mem_addr  out  ADDR_W  registered memory address.
- mem_data  out  DATA_W  registered memory write data.
- mem_wren  out  1  registered write enable.
- mem_q  in  DATA_W  memory read data.
- stall_count  out  16  command stall counter (see Optional Feature).

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - Reset is synchronous, active-low (rst_n), sampled on the rising edge of clk.
- Reset values:
  - mem_addr, mem_data, vga_data, rd_data, stall_count = 0.
  - mem_wren, vga_valid, rd_valid = 0.
  - FSM = IDLE; tag pipeline cleared.
- Arbitration, evaluated every cycle:
  - cmd_ready = rst_n & (state == IDLE) & ~vga_req. cmd_ready is combinational.
  - If vga_req is high, the VGA access is issued and the command waits.
  - Otherwise, if cmd_valid & cmd_ready, the command is issued.
  - Otherwise no access is issued: mem_wren = 0 and mem_addr holds its last value.
- Issue:
  - On the clock edge where an access is granted, mem_addr is loaded with the granted address.
  - A write also sets mem_wren = 1 for exactly one cycle and loads mem_data with cmd_wdata.
  - mem_wren is never high for a VGA access.
- Return pipeline:
  - A tag shift register of length MEM_LAT carries the source of each access: {none, VGA, CMD_RD}.
  - When a tag reaches the end, mem_q is captured into vga_data or rd_data and the matching valid is pulsed for one cycle.
  - Latency from a sampled vga_req (or an accepted read) to its valid pulse = MEM_LAT + 1 cycles.
  - VGA returns are in order. Back-to-back vga_req gives back-to-back vga_valid.
- Command FSM:
  - IDLE: an accepted write stays in IDLE (complete on acceptance). An accepted read moves to RD_WAIT.
  - RD_WAIT: cmd_ready = 0. On the cycle rd_valid pulses, return to IDLE. cmd_ready may rise in the following cycle.
  - At most one command read is outstanding.
- Hold behaviour:
  - vga_data and rd_data hold their last value between valid pulses.
- Boundary conditions:
  - vga_req and cmd_valid high in the same cycle: the VGA access wins, cmd_ready = 0, and the command must stay stable until accepted.
  - Continuous vga_req (active line): the command port is starved. This is allowed; the command is accepted in the first non-vga_req cycle (blanking).
  - Write immediately followed by a read to the same address: the read returns the new data. The memory is read-after-write ordered per issue cycle.
  - Address arithmetic wraps at 2^ADDR_W; the block does no range checking.
  - Reset asserted mid-read: the tag pipeline is flushed, rd_valid and vga_valid never pulse for the dropped accesses, and the FSM returns to IDLE.

Optional Feature:
- Macro: FRAME_ARB_STATS_EN.
- Defined:
  - stall_count increments by 1 on every cycle with cmd_valid = 1 and cmd_ready = 0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Not defined: stall_count is tied to 0 and no counter logic is built.

Test Plan:
- Reset check: rst_n low for 3 cycles with vga_req = 1 and cmd_valid = 1 -> all outputs 0, cmd_ready = 0, no valid pulses until 4 cycles after rst_n rises.
- VGA stream (MEM_LAT = 2): vga_req high 8 cycles, addresses 0x0100..0x0107, memory preloaded with data = addr[7:0] -> vga_valid high 8 consecutive cycles starting 3 cycles after the first request; vga_data 0x00..0x07 in order.
- Conflict: write 0xA5 to 0x1234 while vga_req is high -> cmd_ready = 0 until vga_req drops; write issued the next cycle with one mem_wren pulse at mem_addr = 0x1234.
- Read-after-write: write 0x3C to 0x0010, then read 0x0010 -> rd_valid exactly 3 cycles after read acceptance with rd_data = 0x3C; cmd_ready low during RD_WAIT.
- Reset during RD_WAIT: accept a read, assert rst_n low the next cycle -> no rd_valid pulse; FSM back in IDLE.
- With FRAME_ARB_STATS_EN: cmd_valid held 10 cycles against continuous vga_req -> stall_count = 10. Without the macro -> stall_count stays 0.
